// File: rtl/mor1kx_sprs_pkg.sv
// Shared SPR definitions: tick timer group/address map, TTMR mode encoding and
// the TTMR register layout.
package mor1kx_sprs_pkg;

    localparam int unsigned SPR_GROUP_W = 5;

    localparam logic [SPR_GROUP_W-1:0] SPR_TT_BASE = 5'd10;

    typedef enum logic [15:0] {
        SPR_TTMR_ADDR = 16'h5000,
        SPR_TTCR_ADDR = 16'h5001
    } spr_tt_addr_e;

    typedef enum logic [1:0] {
        TT_DISABLED = 2'b00,
        TT_RESTART  = 2'b01,
        TT_SINGLE   = 2'b10,
        TT_CONT     = 2'b11
    } tt_mode_t;

    typedef struct packed {
        tt_mode_t    mode;
        logic        ie;
        logic        ip;
        logic [27:0] tp;
    } tick_timer_mode_t;

    function automatic logic [SPR_GROUP_W-1:0] spr_group(input logic [15:0] addr);
        return addr[15:11];
    endfunction

endpackage

// File: rtl/mor1kx_tick_prescaler.sv
// Divides the enabled core clock down to timer ticks; one tick every PRESCALE
// enabled cycles. Only instantiated for PRESCALE >= 2.
module mor1kx_tick_prescaler #(
    parameter int PRESCALE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i & (cnt_q == LAST);

    // A clear always wins so a TTCR write restarts the tick phase cleanly.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (tick_o)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mor1kx_tick_timer.sv
// OpenRISC tick timer: TTMR/TTCR on SPR group 10, prescaled counting with
// restart/single-run/continuous modes and a sticky tick interrupt.
module mor1kx_tick_timer
    import mor1kx_sprs_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spr_access_i,
    input  logic        spr_we_i,
    input  logic [15:0] spr_addr_i,
    input  logic [31:0] spr_dat_i,
    output logic        spr_ack_o,
    output logic [31:0] spr_dat_o,
    input  logic        du_stall_i,
    output logic        tt_irq_o
);

    tick_timer_mode_t ttmr_q, ttmr_d;
    logic [31:0]      ttcr_q, ttcr_d;
    logic             stopped_q, stopped_d;
    logic             ack_q;
    logic [31:0]      dat_q, rd_data;
    logic             irq_q, irq_d;

    logic hit, ttmr_we, ttcr_we;
    logic count_en, tick, match;

    // The ack blocks re-acceptance so a held request is served exactly once.
    assign hit     = spr_access_i & (spr_group(spr_addr_i) == SPR_TT_BASE) & ~ack_q;
    assign ttmr_we = hit & spr_we_i & (spr_addr_i == SPR_TTMR_ADDR);
    assign ttcr_we = hit & spr_we_i & (spr_addr_i == SPR_TTCR_ADDR);

    assign count_en = (ttmr_q.mode != TT_DISABLED) & ~stopped_q & ~du_stall_i;

    generate
        if (PRESCALE > 1) begin : g_pre
            mor1kx_tick_prescaler #(
                .PRESCALE(PRESCALE)
            ) u_pre (
                .clk    (clk),
                .rst_n  (rst_n),
                .en_i   (count_en),
                .clr_i  (ttcr_we),
                .tick_o (tick)
            );
        end else begin : g_nopre
            assign tick = count_en;
        end
    endgenerate

    // Match uses the pre-write TP; a same-cycle TTMR write lands next cycle.
    assign match = tick & (ttcr_q[27:0] == ttmr_q.tp);

    always_comb begin
        ttcr_d = ttcr_q;
        if (ttcr_we) begin
            ttcr_d = spr_dat_i;
        end else if (tick) begin
            case (ttmr_q.mode)
                TT_RESTART: ttcr_d = match ? 32'd0 : ttcr_q + 32'd1;
                TT_SINGLE:  ttcr_d = match ? ttcr_q : ttcr_q + 32'd1;
                default:    ttcr_d = ttcr_q + 32'd1;
            endcase
        end
    end

    always_comb begin
        stopped_d = stopped_q;
        if (ttmr_we | ttcr_we)
            stopped_d = 1'b0;
        else if (match & (ttmr_q.mode == TT_SINGLE))
            stopped_d = 1'b1;
    end

    // Software can only clear IP; a hardware set in the same cycle wins.
    always_comb begin
        ttmr_d = ttmr_q;
        if (ttmr_we) begin
            ttmr_d.mode = tt_mode_t'(spr_dat_i[31:30]);
            ttmr_d.ie   = spr_dat_i[29];
            ttmr_d.ip   = spr_dat_i[28] & ttmr_q.ip;
            ttmr_d.tp   = spr_dat_i[27:0];
        end
        ttmr_d.ip = ttmr_d.ip | (match & ttmr_q.ie);
        irq_d     = ttmr_d.ip & ttmr_d.ie;
    end

    always_comb begin
        rd_data = 32'd0;
        if (hit & ~spr_we_i) begin
            if (spr_addr_i == SPR_TTMR_ADDR)
                rd_data = ttmr_q;
            else if (spr_addr_i == SPR_TTCR_ADDR)
                rd_data = ttcr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ttmr_q    <= '0;
            ttcr_q    <= '0;
            stopped_q <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            ttmr_q    <= ttmr_d;
            ttcr_q    <= ttcr_d;
            stopped_q <= stopped_d;
            ack_q     <= hit;
            dat_q     <= rd_data;
            irq_q     <= irq_d;
        end
    end

    assign spr_ack_o = ack_q;
    assign spr_dat_o = dat_q;
    assign tt_irq_o  = irq_q;

endmodule
